// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST inference datapath.
package mnist_pkg;

  localparam int LOGIT_W     = 32;
  localparam int NUM_CLASSES = 10;

  localparam logic signed [LOGIT_W-1:0] LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};
  localparam logic signed [LOGIT_W-1:0] LOGIT_MAX = {1'b0, {(LOGIT_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } argmax_state_t;

endpackage

// File: rtl/sat_margin.sv
// Combinational max-minus-second margin.
// The subtract is done one bit wider than the logits, so it cannot wrap.
// The result is clamped to the largest positive logit value.
module sat_margin #(
  parameter int LOGIT_W = 32
) (
  input  logic signed [LOGIT_W-1:0] i_max,
  input  logic signed [LOGIT_W-1:0] i_second,
  output logic        [LOGIT_W-1:0] o_margin
);

  localparam logic signed [LOGIT_W:0] W_CLAMP = {2'b00, {(LOGIT_W-1){1'b1}}};

  logic signed [LOGIT_W:0] w_diff;

  // Widened subtract, then clamp. A negative result cannot occur when max >= second.
  // Floor it at zero anyway, for safety.
  always_comb begin
    w_diff = {i_max[LOGIT_W-1], i_max} - {i_second[LOGIT_W-1], i_second};
    if (w_diff > W_CLAMP)
      o_margin = W_CLAMP[LOGIT_W-1:0];
    else if (w_diff < 0)
      o_margin = '0;
    else
      o_margin = w_diff[LOGIT_W-1:0];
  end

endmodule

// File: rtl/logits_argmax.sv
// Argmax scan over the FC2 logit buffer.
// The block reads one logit per cycle.
// It presents the class, logit and saturated margin on a valid/ready handshake.
module logits_argmax #(
  parameter int OUT_DIM = 10,
  parameter int LOGIT_W = 32,
  localparam int AW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [AW-1:0]             rd_addr,
  input  logic signed [LOGIT_W-1:0] rd_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [AW-1:0]             res_class,
  output logic signed [LOGIT_W-1:0] res_logit,
  output logic [LOGIT_W-1:0]        res_margin
);
  import mnist_pkg::*;

  localparam logic [AW-1:0]             LAST = AW'(OUT_DIM - 1);
  localparam logic signed [LOGIT_W-1:0] LMIN = {1'b1, {(LOGIT_W-1){1'b0}}};
  localparam logic        [LOGIT_W-1:0] LMAX = {1'b0, {(LOGIT_W-1){1'b1}}};

  argmax_state_t r_state, w_state_n;

  logic                      r_busy, r_done, r_res_valid;
  logic [AW-1:0]             r_k;          // scan index, doubles as read address
  logic [AW-1:0]             r_idx, r_res_class;
  logic signed [LOGIT_W-1:0] r_max, r_sec, r_res_logit;
  logic [LOGIT_W-1:0]        r_res_margin;

  logic [AW-1:0]             w_idx_n;
  logic signed [LOGIT_W-1:0] w_max_n, w_sec_n;
  logic [LOGIT_W-1:0]        w_margin, w_margin_fin;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: if (start)                    w_state_n = SCAN;
      SCAN: if (r_k == LAST)              w_state_n = EMIT;
      EMIT: if (r_res_valid && res_ready) w_state_n = DONE;
      DONE:                               w_state_n = IDLE;
      default:                            w_state_n = IDLE;
    endcase
  end

  // Running max/second update for the logit being read this cycle.
  // A strict compare keeps the lowest index on ties.
  // The later equal value then becomes the second-best logit.
  always_comb begin
    w_max_n = r_max;
    w_sec_n = r_sec;
    w_idx_n = r_idx;
    if (r_k == '0) begin
      w_max_n = rd_data;
      w_sec_n = LMIN;
      w_idx_n = '0;
    end else if (rd_data > r_max) begin
      w_sec_n = r_max;
      w_max_n = rd_data;
      w_idx_n = r_k;
    end else if (rd_data > r_sec) begin
      w_sec_n = rd_data;
    end
  end

  sat_margin #(.LOGIT_W(LOGIT_W)) u_sat_margin (
    .i_max    (w_max_n),
    .i_second (w_sec_n),
    .o_margin (w_margin)
  );

  // A single logit has no runner-up, so its margin is reported as the full scale.
  assign w_margin_fin = (OUT_DIM == 1) ? LMAX : w_margin;

  // Datapath, handshake and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_k          <= '0;
      r_idx        <= '0;
      r_max        <= '0;
      r_sec        <= '0;
      r_res_class  <= '0;
      r_res_logit  <= '0;
      r_res_margin <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k    <= '0;
            r_busy <= 1'b1;
          end
        end
        SCAN: begin
          r_max <= w_max_n;
          r_sec <= w_sec_n;
          r_idx <= w_idx_n;
          if (r_k != LAST) begin
            r_k <= r_k + 1'b1;
          end else begin
            r_res_class  <= w_idx_n;
            r_res_logit  <= w_max_n;
            r_res_margin <= w_margin_fin;
            r_res_valid  <= 1'b1;
          end
        end
        EMIT: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        DONE: r_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rd_addr    = r_k;
  assign res_valid  = r_res_valid;
  assign res_class  = r_res_class;
  assign res_logit  = r_res_logit;
  assign res_margin = r_res_margin;

endmodule

// File: tb/tb_logits_argmax.sv
// Self-checking bench for logits_argmax.
// It uses directed vectors and randomized logits.
// Results are compared against an array-based argmax model.
module tb_logits_argmax;

  localparam int N = 10;
  localparam int W = 32;
  localparam longint SMAX = 64'd2147483647;
  localparam logic signed [W-1:0] LMIN = 32'sh8000_0000;
  localparam logic signed [W-1:0] LMAX = 32'sh7fff_ffff;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic                rst, start, res_ready;
  logic                busy, done, res_valid;
  logic [3:0]          rd_addr, res_class;
  logic signed [W-1:0] rd_data, res_logit;
  logic [W-1:0]        res_margin;
  logic signed [W-1:0] mem [N];

  assign rd_data = (rd_addr < 4'(N)) ? mem[rd_addr] : 32'sd0;

  logits_argmax #(.OUT_DIM(N), .LOGIT_W(W)) dut (
    .clk(gclk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_logit(res_logit), .res_margin(res_margin)
  );

  // Single-class instance for the degenerate OUT_DIM=1 case.
  logic                s_start, s_busy, s_done, s_valid, s_ready;
  logic [0:0]          s_addr, s_class;
  logic signed [W-1:0] s_data, s_logit;
  logic [W-1:0]        s_margin;

  logits_argmax #(.OUT_DIM(1), .LOGIT_W(W)) dut1 (
    .clk(gclk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_addr(s_addr), .rd_data(s_data), .res_valid(s_valid), .res_ready(s_ready),
    .res_class(s_class), .res_logit(s_logit), .res_margin(s_margin)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: first index holding the maximum value.
  // Margin is that maximum minus the largest of all other entries, capped at full scale.
  task automatic model(output longint cls, output longint lg, output longint mg);
    longint best, sec;
    cls = 0;
    best = longint'(mem[0]);
    for (int i = 1; i < N; i++)
      if (longint'(mem[i]) > best) begin
        best = longint'(mem[i]);
        cls  = i;
      end
    sec = -64'sd9223372036854775807;
    for (int i = 0; i < N; i++)
      if (i != cls && longint'(mem[i]) > sec) sec = longint'(mem[i]);
    lg = best;
    mg = (best - sec > SMAX) ? SMAX : best - sec;
  endtask

  // Single scan.
  // Stall cycles hold res_ready low before the handshake.
  // With stall=0, res_ready is already high when the result appears.
  task automatic do_scan(input string tag, input int stall);
    longint ec, el, em;
    int n;
    model(ec, el, em);
    res_ready = (stall == 0);
    @(negedge gclk) start = 1'b1;
    @(negedge gclk) start = 1'b0;
    chk({tag, ".busy"}, longint'(busy), 1);
    n = 1;
    while (!res_valid && n < 40) begin
      @(negedge gclk);
      n++;
    end
    chk({tag, ".lat"}, n, 11);
    chk({tag, ".class"}, longint'(res_class), ec);
    chk({tag, ".logit"}, longint'(res_logit), el);
    chk({tag, ".margin"}, longint'(res_margin), em);
    for (int i = 0; i < stall; i++) @(negedge gclk);
    res_ready = 1'b1;
    @(negedge gclk);
    chk({tag, ".done"}, longint'({done, res_valid, busy}), 64'b100);
    res_ready = 1'b0;
    @(negedge gclk);
    chk({tag, ".done_pulse"}, longint'(done), 0);
  endtask

  task automatic load(input longint v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    longint t [N];
    t = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9};
    for (int i = 0; i < N; i++) mem[i] = W'(t[i]);
  endtask

  initial begin
    longint hc, hl, hm;
    int n;
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    s_start = 1'b0; s_ready = 1'b0; s_data = -32'sd3;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(negedge gclk);
    chk("reset.outs", longint'({busy, done, res_valid, rd_addr, res_class}), 0);
    chk("reset.res", longint'({res_logit, res_margin}), 0);
    rst = 1'b0;
    @(negedge gclk);

    load(-5, 3, 17, 2, 0, -100, 16, 1, 9, 4);
    do_scan("basic", 0);
    chk("basic.margin_abs", longint'(res_margin), 1);
    chk("basic.class_abs", longint'(res_class), 2);

    load(4, 9, 9, 1, 0, 0, 0, 0, 0, 0);
    do_scan("tie", 0);
    chk("tie.margin_abs", longint'(res_margin), 0);

    for (int i = 0; i < N; i++) mem[i] = LMIN;
    mem[9] = LMAX;
    do_scan("sat", 0);
    chk("sat.margin_abs", longint'(res_margin), SMAX);

    for (int i = 0; i < N; i++) mem[i] = -32'sd7;
    do_scan("equal", 0);

    // Stall for 20 cycles. A start pulse mid-stall must be ignored.
    load(1, 2, 3, 50, 5, 6, 7, 8, 9, 10);
    model(hc, hl, hm);
    @(negedge gclk) start = 1'b1;
    @(negedge gclk) start = 1'b0;
    n = 1;
    while (!res_valid && n < 40) begin
      @(negedge gclk);
      n++;
    end
    chk("stall.lat", n, 11);
    for (int c = 0; c < 20; c++) begin
      start = (c == 7);
      @(negedge gclk);
      if (!res_valid || !busy || done || longint'(res_class) != hc ||
          longint'(res_logit) != hl || longint'(res_margin) != hm) begin
        chk("stall.hold", longint'({res_valid, busy, done}), 64'b110);
        chk("stall.hold_res", longint'(res_logit), hl);
      end
    end
    start = 1'b0;
    chk("stall.class", longint'(res_class), hc);
    res_ready = 1'b1;
    @(negedge gclk);
    res_ready = 1'b0;
    chk("stall.done", longint'({done, res_valid, busy}), 64'b100);
    repeat (3) @(negedge gclk);
    chk("stall.no_queue", longint'({busy, res_valid}), 0);

    // Reset while the scan is at index 4.
    load(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    @(negedge gclk) start = 1'b1;
    @(negedge gclk) start = 1'b0;
    n = 0;
    while (rd_addr != 4'd4 && n < 20) begin
      @(negedge gclk);
      n++;
    end
    chk("rst.reach4", longint'(rd_addr), 4);
    rst = 1'b1;
    @(negedge gclk);
    rst = 1'b0;
    chk("rst.outs", longint'({busy, done, res_valid, rd_addr, res_class}), 0);
    chk("rst.res", longint'({res_logit, res_margin}), 0);
    repeat (3) @(negedge gclk);
    chk("rst.idle", longint'({busy, res_valid}), 0);
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    do_scan("after_rst", 0);
    chk("after_rst.margin_abs", longint'(res_margin), 8);

    // Randomized logits.
    // Narrow ranges create ties; full range exercises saturation.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++)
        case (t % 3)
          0: mem[i] = W'($urandom_range(0, 6)) - 32'sd3;
          1: mem[i] = W'($urandom);
          default: mem[i] = ($urandom_range(0, 3) == 0) ? LMIN : W'($urandom_range(0, 1000));
        endcase
      do_scan($sformatf("rnd%0d", t), int'($urandom_range(0, 4)));
    end

    // Single-class instance.
    @(negedge gclk) s_start = 1'b1;
    @(negedge gclk) s_start = 1'b0;
    s_ready = 1'b1;
    n = 1;
    while (!s_valid && n < 20) begin
      @(negedge gclk);
      n++;
    end
    chk("dim1.lat", n, 2);
    chk("dim1.class", longint'(s_class), 0);
    chk("dim1.logit", longint'(s_logit), -3);
    chk("dim1.margin", longint'(s_margin), SMAX);
    @(negedge gclk);
    chk("dim1.done", longint'({s_done, s_valid, s_busy}), 64'b100);
    s_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
